// File: rtl/branch_predictor_pkg.sv
// Shared types, widths and the 2-bit saturating counter helper for the
// GAg branch predictor (also usable by the branch unit).
package branch_predictor_pkg;

  localparam int unsigned PATTERN_WIDTH = 10;
  localparam int unsigned PHT_DEPTH     = 1 << PATTERN_WIDTH;
  localparam int unsigned CNT_WIDTH     = 2;
  localparam int unsigned PERF_WIDTH    = 32;

  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = 2'b01;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

  // Saturating 2-bit counter step: +1 if taken, -1 if not, clamped to 0..3.
  function automatic logic [CNT_WIDTH-1:0] sat2(input logic [CNT_WIDTH-1:0] c,
                                                input logic                 t);
    logic [CNT_WIDTH-1:0] r;
    r = c;
    if (t) begin
      if (c != 2'b11) r = c + 2'd1;
    end else begin
      if (c != 2'b00) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_pht.sv
// Pattern history table: PHT_DEPTH x 2-bit, one async read, one sync write.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o read port.
// A same-cycle write and read at one index returns the old value.
module branch_predictor_pht
  import branch_predictor_pkg::*;
(
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [PATTERN_WIDTH-1:0] waddr_i,
  input  logic [CNT_WIDTH-1:0]     wdata_i,
  input  logic [PATTERN_WIDTH-1:0] raddr_i,
  output logic [CNT_WIDTH-1:0]     rdata_o
);

  logic [CNT_WIDTH-1:0] mem_q [PHT_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_predictor.sv
// GAg two-bit-counter branch predictor.
// Ports: clk, reset (sync, active-high); ready (PHT init done);
// issue side: b_issue in, prediction_begin/pattern_begin out (combinational);
// commit side: commit_b, failure, prediction_end, pattern_end, recover in;
// perf: n_commit, n_fail out.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     b_issue,
  output logic [CNT_WIDTH-1:0]     prediction_begin,
  output logic [PATTERN_WIDTH-1:0] pattern_begin,
  input  logic                     commit_b,
  input  logic                     failure,
  input  logic [CNT_WIDTH-1:0]     prediction_end,
  input  logic [PATTERN_WIDTH-1:0] pattern_end,
  input  logic                     recover,
  output logic [PERF_WIDTH-1:0]    n_commit,
  output logic [PERF_WIDTH-1:0]    n_fail
);

  bp_state_t                state_q, state_d;
  logic [PATTERN_WIDTH-1:0] init_idx_q, init_idx_d;
  logic [PATTERN_WIDTH-1:0] spec_hist_q, spec_hist_d;
  logic [PATTERN_WIDTH-1:0] commit_hist_q, commit_hist_d;
  logic [PERF_WIDTH-1:0]    n_commit_q, n_commit_d;
  logic [PERF_WIDTH-1:0]    n_fail_q, n_fail_d;

  logic                     pht_we;
  logic [PATTERN_WIDTH-1:0] pht_waddr;
  logic [CNT_WIDTH-1:0]     pht_wdata;
  logic [CNT_WIDTH-1:0]     pht_rdata;
  logic                     actual;

  branch_predictor_pht u_pht (
    .clk     (clk),
    .we_i    (pht_we),
    .waddr_i (pht_waddr),
    .wdata_i (pht_wdata),
    .raddr_i (spec_hist_q),
    .rdata_o (pht_rdata)
  );

  // Registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BP_INIT;
      init_idx_q    <= '0;
      spec_hist_q   <= '0;
      commit_hist_q <= '0;
      n_commit_q    <= '0;
      n_fail_q      <= '0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      spec_hist_q   <= spec_hist_d;
      commit_hist_q <= commit_hist_d;
      n_commit_q    <= n_commit_d;
      n_fail_q      <= n_fail_d;
    end
  end

  // Next state, PHT write port muxing (init sweep vs. commit training).
  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    spec_hist_d   = spec_hist_q;
    commit_hist_d = commit_hist_q;
    n_commit_d    = n_commit_q;
    n_fail_d      = n_fail_q;
    pht_we        = 1'b0;
    pht_waddr     = init_idx_q;
    pht_wdata     = CNT_WEAK_NT;
    actual        = prediction_end[1] ^ failure;

    unique case (state_q)
      BP_INIT: begin
        pht_we     = ~reset;
        init_idx_d = init_idx_q + PATTERN_WIDTH'(1);
        if (&init_idx_q) state_d = BP_RUN;
      end
      BP_RUN: begin
        if (commit_b) begin
          pht_we        = ~reset;
          pht_waddr     = pattern_end;
          pht_wdata     = sat2(prediction_end, actual);
          commit_hist_d = {commit_hist_q[PATTERN_WIDTH-2:0], actual};
          n_commit_d    = n_commit_q + PERF_WIDTH'(1);
          n_fail_d      = n_fail_q + PERF_WIDTH'(failure);
        end
        // Recover sees this cycle's commit shift and overrides any issue.
        if (recover) begin
          spec_hist_d = commit_hist_d;
        end else if (b_issue) begin
          spec_hist_d = {spec_hist_q[PATTERN_WIDTH-2:0], pht_rdata[1]};
        end
      end
      default: state_d = BP_INIT;
    endcase
  end

  assign ready            = (state_q == BP_RUN);
  assign prediction_begin = (state_q == BP_RUN) ? pht_rdata : CNT_WEAK_NT;
  assign pattern_begin    = (state_q == BP_RUN) ? spec_hist_q : '0;
  assign n_commit         = n_commit_q;
  assign n_fail           = n_fail_q;

endmodule
